rv32i_single_cycle: RTL and testbench



---
 rtl/rv32i_pkg.sv | 87 ++++++++
 rtl/rv32i_single_cycle_if.sv | 20 ++
 rtl/rv32i_imem.sv | 36 +++
 rtl/rv32i_single_cycle.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_rv32i_single_cycle.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, ALU/immediate enums and immediate extraction.
// Branch/jump support is compiled in with the RV32I_BRANCH_EN macro.
package rv32i_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4
  } wb_sel_t;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] ins,
    input imm_fmt_t    fmt
  );
    logic [31:0] r;
    unique case (fmt)
      IMM_I: r = {{20{ins[31]}}, ins[31:20]};
      IMM_S: r = {{20{ins[31]}}, ins[31:25],
                  ins[11:7]};
      IMM_B: r = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
      IMM_U: r = {ins[31:12], 12'b0};
      IMM_J: r = {{11{ins[31]}}, ins[31],
                  ins[19:12], ins[20],
                  ins[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic alu_op_t alu_sel(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t r;
    unique case (f3)
      F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32i_single_cycle_if.sv
// Instruction-fetch bus between the core and its instruction memory.
// The word write port lets a loader fill the memory; the core ties it off.
interface rv32i_single_cycle_if #(
  parameter int AW = 32
);
  logic [AW-1:0] addr;
  logic [31:0]   instr;
  logic          we;
  logic [31:0]   wdata;

  modport master (
    output addr, we, wdata,
    input  instr
  );

  modport slave (
    input  addr, we, wdata,
    output instr
  );
endinterface

// File: rtl/rv32i_imem.sv
// Byte-array instruction memory, little-endian, combinational read.
// Addresses wrap modulo IMEM_BYTES; contents are not touched by reset.
module rv32i_imem #(
  parameter int IMEM_BYTES = 1024
) (
  input logic                  clk,
  rv32i_single_cycle_if.slave  bus
);
  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0] mem [0:IMEM_BYTES-1];

  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;

  assign w_a0 = bus.addr;
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);

  assign bus.instr = {mem[w_a3], mem[w_a2],
                      mem[w_a1], mem[w_a0]};

  // loader write of one little-endian word
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[w_a0] <= bus.wdata[7:0];
      mem[w_a1] <= bus.wdata[15:8];
      mem[w_a2] <= bus.wdata[23:16];
      mem[w_a3] <= bus.wdata[31:24];
    end
  end

endmodule

// File: rtl/rv32i_single_cycle.sv
// Single-cycle RV32I core: decode, ALU, regfile and data memory inline.
// Define RV32I_BRANCH_EN to add BEQ..BGEU, JAL and JALR.
module rv32i_single_cycle
  import rv32i_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter int          DMEM_BYTES = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_BYTES);

  logic [31:0] r_pc;
  logic [31:0] r_regs [0:31];
  logic [7:0]  r_dmem [0:DMEM_BYTES-1];

  rv32i_single_cycle_if #(.AW(IAW)) w_ibus ();

  rv32i_imem #(
    .IMEM_BYTES (IMEM_BYTES)
  ) Imm_mem (
    .clk (clk),
    .bus (w_ibus)
  );

  assign w_ibus.addr  = r_pc[IAW-1:0];
  assign w_ibus.we    = 1'b0;
  assign w_ibus.wdata = '0;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  assign w_instr  = w_ibus.instr;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_f7     = w_instr[31:25];

  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];

  logic w_is_r;
  logic w_is_i;
  logic w_is_lui;
  logic w_is_auipc;
  logic w_is_ld;
  logic w_is_st;
  logic w_r_ok;
  logic w_i_ok;

  assign w_is_r     = (w_opcode == OP_R);
  assign w_is_i     = (w_opcode == OP_I);
  assign w_is_lui   = (w_opcode == OP_LUI);
  assign w_is_auipc = (w_opcode == OP_AUIPC);
  assign w_is_ld    = (w_opcode == OP_LOAD);
  assign w_is_st    = (w_opcode == OP_STORE);

  // funct7 may only carry the alternate bit on ADD/SUB and SRL/SRA
  assign w_r_ok = (w_f7 == F7_BASE) ||
                  ((w_f7 == F7_ALT) &&
                   (w_f3 == F3_ADD || w_f3 == F3_SR));

  assign w_i_ok = (w_f3 == F3_SLL) ? (w_f7 == F7_BASE) :
                  (w_f3 == F3_SR)  ? (w_f7 == F7_BASE ||
                                      w_f7 == F7_ALT) :
                  1'b1;

`ifdef RV32I_BRANCH_EN
  logic w_is_br;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_br;
  logic w_jal;
  logic w_jalr;

  assign w_is_br   = (w_opcode == OP_BR);
  assign w_is_jal  = (w_opcode == OP_JAL);
  assign w_is_jalr = (w_opcode == OP_JALR);
`endif

  logic     w_rf_we;
  logic     w_mem_we;
  logic     w_use_imm;
  logic     w_a_pc;
  alu_op_t  w_alu_op;
  imm_fmt_t w_fmt;
  wb_sel_t  w_wb;

  // decode; anything unrecognised falls through as a NOP
  always_comb begin
    w_rf_we   = 1'b0;
    w_mem_we  = 1'b0;
    w_use_imm = 1'b0;
    w_a_pc    = 1'b0;
    w_alu_op  = ALU_ADD;
    w_fmt     = IMM_I;
    w_wb      = WB_ALU;
`ifdef RV32I_BRANCH_EN
    w_br      = 1'b0;
    w_jal     = 1'b0;
    w_jalr    = 1'b0;
`endif
    unique case (1'b1)
      w_is_r: begin
        if (w_r_ok) begin
          w_rf_we  = 1'b1;
          w_alu_op = alu_sel(w_f3, w_f7[5]);
        end
      end
      w_is_i: begin
        if (w_i_ok) begin
          w_rf_we   = 1'b1;
          w_use_imm = 1'b1;
          w_alu_op  = alu_sel(w_f3,
                        (w_f3 == F3_SR) && w_f7[5]);
        end
      end
      w_is_lui: begin
        w_rf_we   = 1'b1;
        w_use_imm = 1'b1;
        w_fmt     = IMM_U;
        w_alu_op  = ALU_PASSB;
      end
      w_is_auipc: begin
        w_rf_we   = 1'b1;
        w_use_imm = 1'b1;
        w_a_pc    = 1'b1;
        w_fmt     = IMM_U;
      end
      w_is_ld: begin
        if (w_f3 == F3_W) begin
          w_rf_we   = 1'b1;
          w_use_imm = 1'b1;
          w_wb      = WB_MEM;
        end
      end
      w_is_st: begin
        if (w_f3 == F3_W) begin
          w_mem_we  = 1'b1;
          w_use_imm = 1'b1;
          w_fmt     = IMM_S;
        end
      end
`ifdef RV32I_BRANCH_EN
      w_is_br: begin
        if (w_f3 != 3'b010 && w_f3 != 3'b011) begin
          w_br  = 1'b1;
          w_fmt = IMM_B;
        end
      end
      w_is_jal: begin
        w_rf_we = 1'b1;
        w_jal   = 1'b1;
        w_fmt   = IMM_J;
        w_wb    = WB_PC4;
      end
      w_is_jalr: begin
        if (w_f3 == 3'b000) begin
          w_rf_we = 1'b1;
          w_jalr  = 1'b1;
          w_wb    = WB_PC4;
        end
      end
`endif
      default: ;
    endcase
  end

  logic [31:0] w_imm;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu;

  assign w_imm   = imm_gen(w_instr, w_fmt);
  assign w_op_a  = w_a_pc ? r_pc : w_rs1_val;
  assign w_op_b  = w_use_imm ? w_imm : w_rs2_val;
  assign w_shamt = w_op_b[4:0];

  // ALU; all arithmetic wraps at 32 bits
  always_comb begin
    w_alu = '0;
    unique case (w_alu_op)
      ALU_ADD:   w_alu = w_op_a + w_op_b;
      ALU_SUB:   w_alu = w_op_a - w_op_b;
      ALU_SLL:   w_alu = w_op_a << w_shamt;
      ALU_SLT:   w_alu = {31'b0,
                   $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU:  w_alu = {31'b0, w_op_a < w_op_b};
      ALU_XOR:   w_alu = w_op_a ^ w_op_b;
      ALU_SRL:   w_alu = w_op_a >> w_shamt;
      ALU_SRA:   w_alu = 32'($signed(w_op_a) >>> w_shamt);
      ALU_OR:    w_alu = w_op_a | w_op_b;
      ALU_AND:   w_alu = w_op_a & w_op_b;
      ALU_PASSB: w_alu = w_op_b;
      default:   w_alu = '0;
    endcase
  end

  logic [DAW-1:0] w_ea;
  logic [DAW-1:0] w_d0;
  logic [DAW-1:0] w_d1;
  logic [DAW-1:0] w_d2;
  logic [DAW-1:0] w_d3;
  logic [31:0]    w_load;

  // word access only: the low two address bits are dropped
  assign w_ea = w_rs1_val[DAW-1:0] + w_imm[DAW-1:0];
  assign w_d0 = {w_ea[DAW-1:2], 2'b00};
  assign w_d1 = {w_ea[DAW-1:2], 2'b01};
  assign w_d2 = {w_ea[DAW-1:2], 2'b10};
  assign w_d3 = {w_ea[DAW-1:2], 2'b11};

  assign w_load = {r_dmem[w_d3], r_dmem[w_d2],
                   r_dmem[w_d1], r_dmem[w_d0]};

  logic [31:0] w_pc4;
  logic [31:0] w_wb_data;
  logic [31:0] w_next_pc;

  assign w_pc4 = r_pc + 32'd4;

  // writeback source select
  always_comb begin
    w_wb_data = w_alu;
    unique case (w_wb)
      WB_MEM:  w_wb_data = w_load;
      WB_PC4:  w_wb_data = w_pc4;
      default: w_wb_data = w_alu;
    endcase
  end

`ifdef RV32I_BRANCH_EN
  logic w_taken;

  // branch condition from the current (pre-write) operands
  always_comb begin
    w_taken = 1'b0;
    unique case (w_f3)
      F3_BEQ:  w_taken = (w_rs1_val == w_rs2_val);
      F3_BNE:  w_taken = (w_rs1_val != w_rs2_val);
      F3_BLT:  w_taken = $signed(w_rs1_val) <
                         $signed(w_rs2_val);
      F3_BGE:  w_taken = $signed(w_rs1_val) >=
                         $signed(w_rs2_val);
      F3_BLTU: w_taken = (w_rs1_val < w_rs2_val);
      F3_BGEU: w_taken = (w_rs1_val >= w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  // next PC; jump targets use rs1 before rd is overwritten
  always_comb begin
    w_next_pc = w_pc4;
    if (w_br && w_taken) begin
      w_next_pc = r_pc + w_imm;
    end else if (w_jal) begin
      w_next_pc = r_pc + w_imm;
    end else if (w_jalr) begin
      w_next_pc = (w_rs1_val + w_imm) & ~32'd1;
    end
  end
`else
  assign w_next_pc = w_pc4;
`endif

  // PC and register file commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pc <= w_next_pc;
      if (w_rf_we && w_rd != 5'd0) begin
        r_regs[w_rd] <= w_wb_data;
      end
    end
  end

  // data memory store; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) begin
      r_dmem[w_d0] <= w_rs2_val[7:0];
      r_dmem[w_d1] <= w_rs2_val[15:8];
      r_dmem[w_d2] <= w_rs2_val[23:16];
      r_dmem[w_d3] <= w_rs2_val[31:24];
    end
  end

endmodule

// File: tb/tb_rv32i_single_cycle.sv
// Testbench for rv32i_single_cycle: directed ISA steps then a random
// program checked against an instruction-level reference model.
module tb_rv32i_single_cycle;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  rv32i_single_cycle #(
    .IMEM_BYTES (1024),
    .DMEM_BYTES (1024),
    .RESET_PC   (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  rv32i_single_cycle_if mon ();
  assign mon.addr  = dut.r_pc;
  assign mon.instr = dut.w_instr;
  assign mon.we    = 1'b0;
  assign mon.wdata = '0;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog");
  end

  typedef enum int {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR,
    K_SRL, K_SRA, K_OR, K_AND,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI,
    K_SLLI, K_SRLI, K_SRAI,
    K_LUI, K_AUIPC, K_LW, K_SW, K_BAD
  } kind_t;

  logic [31:0] exp_r [32];
  logic [31:0] m_reg [32];
  logic [7:0]  m_mem [1024];
  logic [31:0] m_pc;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int unsigned a, logic [31:0] w);
    for (int k = 0; k < 4; k++)
      dut.Imm_mem.mem[(a + k) % 1024] = w[8*k +: 8];
  endtask

  task automatic chk_regs(string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_x%0d", tag, i),
          dut.r_regs[i], exp_r[i]);
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 32; i++) exp_r[i] = '0;
  endtask

  function automatic logic [31:0] e_r(
    logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] e_i(
    logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
    logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_s(
    logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0],
            7'b0100011};
  endfunction

  function automatic logic [31:0] e_b(
    logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] e_j(
    logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] rd_m(logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_reg[r];
  endfunction

  // instruction-level model: one retired instruction per call
  task automatic model_exec(kind_t k, logic [4:0] rd,
                            logic [4:0] rs1, logic [4:0] rs2,
                            logic [31:0] imm);
    logic [31:0] a, b, r;
    int unsigned sh, ea;
    bit wr;
    a  = rd_m(rs1);
    b  = rd_m(rs2);
    r  = 0;
    wr = 1;
    sh = (k inside {K_SLL, K_SRL, K_SRA}) ? b % 32
                                          : imm % 32;
    case (k)
      K_ADD:   r = a + b;
      K_SUB:   r = a - b;
      K_SLT:   r = (int'(a) < int'(b)) ? 1 : 0;
      K_SLTU:  r = (a < b) ? 1 : 0;
      K_XOR:   r = a ^ b;
      K_OR:    r = a | b;
      K_AND:   r = a & b;
      K_ADDI:  r = a + imm;
      K_SLTI:  r = (int'(a) < int'(imm)) ? 1 : 0;
      K_SLTIU: r = (a < imm) ? 1 : 0;
      K_XORI:  r = a ^ imm;
      K_ORI:   r = a | imm;
      K_ANDI:  r = a & imm;
      K_SLL, K_SLLI: r = a * (2 ** sh);
      K_SRL, K_SRLI: r = a / (2 ** sh);
      K_SRA, K_SRAI: begin
        r = a / (2 ** sh);
        if (a[31]) r = r | ~(32'hFFFF_FFFF / (2 ** sh));
      end
      K_LUI:   r = imm * 4096;
      K_AUIPC: r = m_pc + imm * 4096;
      K_LW: begin
        ea = ((a + imm) % 1024) / 4 * 4;
        r = {m_mem[ea+3], m_mem[ea+2],
             m_mem[ea+1], m_mem[ea]};
      end
      K_SW: begin
        wr = 0;
        ea = ((a + imm) % 1024) / 4 * 4;
        for (int q = 0; q < 4; q++)
          m_mem[ea+q] = b[8*q +: 8];
      end
      default: wr = 0;
    endcase
    if (wr && rd != 0) m_reg[rd] = r;
    m_pc = m_pc + 4;
  endtask

  function automatic logic [31:0] enc(kind_t k,
    logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
    logic [31:0] imm, int var_sel, logic [31:0] junk);
    case (k)
      K_ADD:   return e_r(7'h00, rs2, rs1, 3'd0, rd);
      K_SUB:   return e_r(7'h20, rs2, rs1, 3'd0, rd);
      K_SLL:   return e_r(7'h00, rs2, rs1, 3'd1, rd);
      K_SLT:   return e_r(7'h00, rs2, rs1, 3'd2, rd);
      K_SLTU:  return e_r(7'h00, rs2, rs1, 3'd3, rd);
      K_XOR:   return e_r(7'h00, rs2, rs1, 3'd4, rd);
      K_SRL:   return e_r(7'h00, rs2, rs1, 3'd5, rd);
      K_SRA:   return e_r(7'h20, rs2, rs1, 3'd5, rd);
      K_OR:    return e_r(7'h00, rs2, rs1, 3'd6, rd);
      K_AND:   return e_r(7'h00, rs2, rs1, 3'd7, rd);
      K_ADDI:  return e_i(imm, rs1, 3'd0, rd, 7'h13);
      K_SLTI:  return e_i(imm, rs1, 3'd2, rd, 7'h13);
      K_SLTIU: return e_i(imm, rs1, 3'd3, rd, 7'h13);
      K_XORI:  return e_i(imm, rs1, 3'd4, rd, 7'h13);
      K_ORI:   return e_i(imm, rs1, 3'd6, rd, 7'h13);
      K_ANDI:  return e_i(imm, rs1, 3'd7, rd, 7'h13);
      K_SLLI:  return e_i(imm, rs1, 3'd1, rd, 7'h13);
      K_SRLI:  return e_i(imm, rs1, 3'd5, rd, 7'h13);
      K_SRAI:  return e_i(imm | 32'h400, rs1, 3'd5,
                          rd, 7'h13);
      K_LUI:   return {imm[19:0], rd, 7'b0110111};
      K_AUIPC: return {imm[19:0], rd, 7'b0010111};
      K_LW:    return e_i(imm, rs1, 3'd2, rd, 7'h03);
      K_SW:    return e_s(imm, rs2, rs1);
      default: begin
        if (var_sel == 0) return 32'h0;
        if (var_sel == 1) return {junk[24:0], 7'h7F};
        return e_r(7'h01, rs2, rs1, 3'd0, rd);
      end
    endcase
  endfunction

  kind_t       p_k   [200];
  logic [4:0]  p_rd  [200];
  logic [4:0]  p_rs1 [200];
  logic [4:0]  p_rs2 [200];
  logic [31:0] p_imm [200];

  initial begin
    for (int i = 0; i < 1024; i++) dut.Imm_mem.mem[i] = 8'h00;
    clr_exp();

    // reset
    reset = 1'b1;
    step();
    chk("rst_pc", mon.addr, 32'h0);
    chk_regs("rst");
    reset = 1'b0;

    // basic program
    load(0,  32'h01000093);
    load(4,  32'h01008113);
    load(8,  32'h401101B3);
    load(12, 32'h00119233);
    load(16, 32'h0030A023);
    load(20, 32'h0000A283);
    step(); exp_r[1] = 32'h10;
    chk("addi_pc", mon.addr, 32'd4); chk_regs("addi");
    step(); exp_r[2] = 32'h20;
    chk("addi2_x2", dut.r_regs[2], exp_r[2]);
    step(); exp_r[3] = 32'h10;
    chk("sub_x3", dut.r_regs[3], exp_r[3]);
    step(); exp_r[4] = 32'h0010_0000;
    chk("sll_x4", dut.r_regs[4], exp_r[4]);
    step();
    chk("sw_b0", {24'h0, dut.r_dmem[16]}, 32'h10);
    chk("sw_b1", {24'h0, dut.r_dmem[17]}, 32'h00);
    chk("sw_b2", {24'h0, dut.r_dmem[18]}, 32'h00);
    chk("sw_b3", {24'h0, dut.r_dmem[19]}, 32'h00);
    step(); exp_r[5] = 32'h10;
    chk("lw_pc", mon.addr, 32'd24); chk_regs("lw");

    // edge cases
    load(24, e_i(5, 0, 3'd0, 0, 7'h13));
    load(28, e_i(32'hFFF, 0, 3'd0, 6, 7'h13));
    load(32, e_i(32'h404, 6, 3'd5, 7, 7'h13));
    load(36, e_i(4, 6, 3'd5, 8, 7'h13));
    load(40, e_i(1, 0, 3'd0, 9, 7'h13));
    load(44, e_r(7'h00, 9, 6, 3'd2, 10));
    load(48, e_r(7'h00, 9, 6, 3'd3, 11));
    for (int i = 0; i < 7; i++) step();
    exp_r[6]  = 32'hFFFF_FFFF;
    exp_r[7]  = 32'hFFFF_FFFF;
    exp_r[8]  = 32'h0FFF_FFFF;
    exp_r[9]  = 32'h1;
    exp_r[10] = 32'h1;
    exp_r[11] = 32'h0;
    chk("edge_pc", mon.addr, 32'd52); chk_regs("edge");

    // zero words are NOPs
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nop_pc", mon.addr, 32'd56 + 4 * i);
    end
    chk_regs("nop");

    // reset mid-program; data memory survives
    reset = 1'b1;
    step();
    reset = 1'b0;
    clr_exp();
    chk("mrst_pc", mon.addr, 32'h0); chk_regs("mrst");
    chk("mrst_dm", {dut.r_dmem[19], dut.r_dmem[18],
                    dut.r_dmem[17], dut.r_dmem[16]},
        32'h10);

    // branch / jump encodings
    load(0,  e_i(7, 0, 3'd0, 1, 7'h13));
    load(4,  e_i(7, 0, 3'd0, 3, 7'h13));
    load(8,  e_b(8, 3, 1, 3'd0));
    load(12, e_i(1, 0, 3'd0, 2, 7'h13));
    load(16, e_j(32'hFFFF_FFFC, 1));
    step(); step();
    exp_r[1] = 7; exp_r[3] = 7;
    step();
`ifdef RV32I_BRANCH_EN
    chk("beq_pc", mon.addr, 32'd16);
    step(); exp_r[1] = 32'd20;
    chk("jal_pc", mon.addr, 32'd12);
    chk_regs("jal");
`else
    chk("beq_pc", mon.addr, 32'd12);
    step(); exp_r[2] = 1;
    chk("beq_fall_pc", mon.addr, 32'd16);
    step();
    chk("jal_pc", mon.addr, 32'd20);
    chk_regs("jal");
`endif

    // random program vs reference model
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
    m_mem[16] = 8'h10;
    m_pc = 0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] r;
      r        = $urandom;
      p_k[i]   = kind_t'($urandom_range(0, int'(K_BAD)));
      p_rd[i]  = 5'($urandom_range(0, 31));
      p_rs1[i] = 5'($urandom_range(0, 31));
      p_rs2[i] = 5'($urandom_range(0, 31));
      if (p_k[i] inside {K_SLLI, K_SRLI, K_SRAI})
        p_imm[i] = {27'h0, r[4:0]};
      else if (p_k[i] inside {K_LUI, K_AUIPC})
        p_imm[i] = {12'h0, r[19:0]};
      else
        p_imm[i] = {{20{r[11]}}, r[11:0]};
      load(4 * i, enc(p_k[i], p_rd[i], p_rs1[i],
                      p_rs2[i], p_imm[i],
                      int'($urandom_range(0, 2)), $urandom));
    end
    step();
    reset = 1'b0;
    chk("rnd_rst_pc", mon.addr, 32'h0);
    for (int i = 0; i < 200; i++) begin
      model_exec(p_k[i], p_rd[i], p_rs1[i], p_rs2[i],
                 p_imm[i]);
      step();
      chk($sformatf("rnd%0d_pc", i), mon.addr, m_pc);
      for (int j = 0; j < 32; j++)
        chk($sformatf("rnd%0d_x%0d", i, j),
            (j == 0) ? 32'd0 : dut.r_regs[j], rd_m(5'(j)));
    end
    chk("rnd_x0_raw", dut.r_regs[0], 32'd0);
    for (int i = 0; i < 1024; i++)
      chk($sformatf("rnd_dm%0d", i),
          {24'h0, dut.r_dmem[i]}, {24'h0, m_mem[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
